// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, register count and address/data types for the scoreboarded register file
package regfile_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam bit DEF_BYPASS = 1'b1;
  localparam int NREG = 2 ** DEF_ADDR_W;
  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;
  localparam reg_addr_t ZERO_ADDR = '0;
endpackage

// File: rtl/regfile_pend_tracker.sv
// regfile_pend_tracker: per-register pending-write bits, WAW allocation check and pending count
module regfile_pend_tracker
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   reg_w,
  input  logic [ADDR_W-1:0]      w_reg_addr,
  input  logic                   alloc_en,
  input  logic [ADDR_W-1:0]      alloc_addr,
  output logic                   alloc_ok,
  output logic [2**ADDR_W-1:0]   pend,
  output logic [ADDR_W:0]        pend_count
);
  localparam int N = 2 ** ADDR_W;
  logic [N-1:0] pend_q, pend_d, set_mask, clr_mask;
  logic [ADDR_W:0] pend_count_q, pend_count_d;
  logic wr_clr, alloc_set, inc, dec;
  always_comb begin
    wr_clr = reg_w && w_reg_addr != '0;
    alloc_ok = alloc_en && !clr && (alloc_addr == '0 || !pend_q[alloc_addr] || (reg_w && w_reg_addr == alloc_addr));
    alloc_set = alloc_ok && alloc_addr != '0;
    set_mask = alloc_set ? N'(1) << alloc_addr : '0;
    clr_mask = wr_clr ? N'(1) << w_reg_addr : '0;
    inc = alloc_set && !pend_q[alloc_addr];
    dec = wr_clr && pend_q[w_reg_addr] && !(alloc_set && alloc_addr == w_reg_addr);
    pend_d = clr ? '0 : (pend_q & ~clr_mask) | set_mask;
    pend_count_d = clr ? '0 : pend_count_q + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
  end
  always_ff @(posedge clk) begin
    pend_q <= pend_d;
    pend_count_q <= pend_count_d;
  end
  assign pend = pend_q;
  assign pend_count = pend_count_q;
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 2R1W register file, r0 hardwired zero, optional write bypass, pending-write scoreboard
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter bit BYPASS = DEF_BYPASS
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [ADDR_W-1:0] r_reg1,
  input  logic [ADDR_W-1:0] r_reg2,
  output logic [DATA_W-1:0] r_data1,
  output logic [DATA_W-1:0] r_data2,
  output logic              r_pend1,
  output logic              r_pend2,
  input  logic [ADDR_W-1:0] w_reg_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              reg_w,
  input  logic              alloc_en,
  input  logic [ADDR_W-1:0] alloc_addr,
  output logic              alloc_ok,
  output logic [ADDR_W:0]   pend_count
);
  localparam int N = 2 ** ADDR_W;
  logic [DATA_W-1:0] mem_q [N];
  logic [DATA_W-1:0] mem_d [N];
  logic [N-1:0] pend;
  logic byp1, byp2;
  regfile_pend_tracker #(.ADDR_W(ADDR_W)) u_pend (
    .clk(clk),
    .clr(clr),
    .reg_w(reg_w),
    .w_reg_addr(w_reg_addr),
    .alloc_en(alloc_en),
    .alloc_addr(alloc_addr),
    .alloc_ok(alloc_ok),
    .pend(pend),
    .pend_count(pend_count)
  );
  always_comb begin
    for (int i = 0; i < N; i++)
      mem_d[i] = clr ? '0 : (reg_w && w_reg_addr != '0 && w_reg_addr == ADDR_W'(i)) ? w_data : mem_q[i];
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  always_comb begin
    byp1 = BYPASS && reg_w && r_reg1 != '0 && w_reg_addr == r_reg1;
    byp2 = BYPASS && reg_w && r_reg2 != '0 && w_reg_addr == r_reg2;
    r_data1 = r_reg1 == '0 ? '0 : byp1 ? w_data : mem_q[r_reg1];
    r_data2 = r_reg2 == '0 ? '0 : byp2 ? w_data : mem_q[r_reg2];
    r_pend1 = !byp1 && pend[r_reg1];
    r_pend2 = !byp2 && pend[r_reg2];
  end
endmodule
